// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the data-memory responder: RISC-V cause
// codes, request size and reservation encodings, the response record and
// the FSM state type.
package mem_responder_pkg;

    localparam logic [3:0] LOAD_MISALIGNED    = 4'd4;
    localparam logic [3:0] LOAD_ACCESS_FAULT  = 4'd5;
    localparam logic [3:0] STORE_MISALIGNED   = 4'd6;
    localparam logic [3:0] STORE_ACCESS_FAULT = 4'd7;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_BAD  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        RESV_NONE    = 2'b00,
        RESV_SET     = 2'b01,
        RESV_SC_OK   = 2'b10,
        RESV_SC_FAIL = 2'b11
    } resv_e;

    typedef enum logic [1:0] {
        STATE_IDLE   = 2'd0,
        STATE_ACCESS = 2'd1,
        STATE_RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] data;
    } exception_t;

    // Same field order as the core's memRead_res record.
    typedef struct packed {
        logic [31:0] data;
        resv_e       reservation;
        exception_t  exception;
    } mem_res_t;

    // A size of 3 has no legal alignment, so it always reports misaligned.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] offset);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = offset[0];
            SIZE_WORD: mis = |offset;
            default:   mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the right-aligned core data and the 32-bit
// SRAM word: write strobes and replicated write data going out, shifted and
// zero-extended read data coming back.
module mem_lane_align
    import mem_responder_pkg::*;
(
    input  size_e       size_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    input  logic [31:0] rdata_i,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    // Pick strobes, replicate store data and extract the addressed lane(s) by size.
    always_comb begin
        shifted = rdata_i >> {offset_i, 3'b000};
        wstrb_o = 4'b0000;
        wdata_o = 32'd0;
        rdata_o = 32'd0;
        case (size_i)
            SIZE_BYTE: begin
                wstrb_o = 4'b0001 << offset_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {24'd0, shifted[7:0]};
            end
            SIZE_HALF: begin
                wstrb_o = 4'b0011 << offset_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {16'd0, shifted[15:0]};
            end
            SIZE_WORD: begin
                wstrb_o = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = shifted;
            end
            default: begin
                wstrb_o = 4'b0000;
                wdata_o = 32'd0;
                rdata_o = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Responder for the core's data-memory interface. Takes one load, store,
// LR or SC at a time, checks alignment and address window, runs the access
// on a variable-latency word SRAM port and returns a one-cycle response with
// data, reservation status and exception record.
// Optional build macro MEM_RESPONDER_TIMEOUT_EN: abort an SRAM access that
// has not been acknowledged within TIMEOUT_CYCLES and report an access fault.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter logic [31:0] MEM_BASE       = 32'h0000_0000,
    parameter int unsigned MEM_BYTES      = 65536,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_lr,
    input  logic        req_sc,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic [1:0]  res_reservation,
    output logic        res_exception_valid,
    output logic [3:0]  res_exception_data,
    output logic        sram_en,
    output logic        sram_we,
    output logic [29:0] sram_addr,
    output logic [31:0] sram_wdata,
    output logic [3:0]  sram_wstrb,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ack
);

    localparam logic [32:0] WINDOW_BYTES = 33'(MEM_BYTES);
    localparam logic [29:0] BASE_WORD    = MEM_BASE[31:2];

    if (MEM_BYTES < 4 || (MEM_BYTES & (MEM_BYTES - 1)) != 0) begin : g_bad_window
        $error("mem_responder: MEM_BYTES must be a power of two and at least 4");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mem_responder: TIMEOUT_CYCLES must be in 1..65535");
    end

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic        lr_q, lr_d;
    logic        sc_q, sc_d;
    size_e       size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    mem_res_t    res_q, res_d;
    logic        resvValid_q, resvValid_d;
    logic [29:0] resvWord_q, resvWord_d;

`ifdef MEM_RESPONDER_TIMEOUT_EN
    localparam logic [15:0] TIMER_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] timer_q, timer_d;
`endif

    logic        reqIsSc;
    logic        reqIsLr;
    logic        reqIsWrite;
    logic        reqMisaligned;
    logic        reqOutOfRange;
    logic        reqResvHit;
    logic        accResvHit;
    logic [31:0] reqOffset;
    logic [31:0] laneWdata;
    logic [3:0]  laneWstrb;
    logic [31:0] laneRdata;

    mem_lane_align u_lane (
        .size_i   (size_q),
        .offset_i (addr_q[1:0]),
        .wdata_i  (data_q),
        .wdata_o  (laneWdata),
        .wstrb_o  (laneWstrb),
        .rdata_i  (sram_rdata),
        .rdata_o  (laneRdata)
    );

    // Classify the incoming request; SC wins over LR, and LR overrides req_write.
    always_comb begin
        reqIsSc       = req_sc;
        reqIsLr       = req_lr & ~req_sc;
        reqIsWrite    = req_sc | (req_write & ~reqIsLr);
        reqMisaligned = is_misaligned(size_e'(req_size), req_addr[1:0]);
        reqOffset     = req_addr - MEM_BASE;
        reqOutOfRange = {1'b0, reqOffset} >= WINDOW_BYTES;
        reqResvHit    = resvValid_q && (resvWord_q == req_addr[31:2]);
        accResvHit    = resvValid_q && (resvWord_q == addr_q[31:2]);
    end

    // Next-state logic: accept and check in IDLE, wait for the SRAM in ACCESS, pulse in RESP.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        lr_d        = lr_q;
        sc_d        = sc_q;
        size_d      = size_q;
        addr_d      = addr_q;
        data_d      = data_q;
        res_d       = res_q;
        resvValid_d = resvValid_q;
        resvWord_d  = resvWord_q;
`ifdef MEM_RESPONDER_TIMEOUT_EN
        timer_d     = timer_q;
`endif
        unique case (state_q)
            STATE_IDLE: begin
                if (req_valid) begin
                    write_d = reqIsWrite;
                    lr_d    = reqIsLr;
                    sc_d    = reqIsSc;
                    size_d  = size_e'(req_size);
                    addr_d  = req_addr;
                    data_d  = req_data;
                    res_d   = '0;
`ifdef MEM_RESPONDER_TIMEOUT_EN
                    timer_d = 16'd0;
`endif
                    if (reqMisaligned) begin
                        res_d.exception.valid = 1'b1;
                        res_d.exception.data  = reqIsWrite ? STORE_MISALIGNED : LOAD_MISALIGNED;
                        state_d = STATE_RESP;
                    end else if (reqOutOfRange) begin
                        res_d.exception.valid = 1'b1;
                        res_d.exception.data  = reqIsWrite ? STORE_ACCESS_FAULT : LOAD_ACCESS_FAULT;
                        state_d = STATE_RESP;
                    end else if (reqIsSc && !reqResvHit) begin
                        res_d.data        = 32'd1;
                        res_d.reservation = RESV_SC_FAIL;
                        resvValid_d       = 1'b0;
                        state_d           = STATE_RESP;
                    end else begin
                        state_d = STATE_ACCESS;
                    end
                end
            end
            STATE_ACCESS: begin
                if (sram_ack) begin
                    state_d = STATE_RESP;
                    res_d   = '0;
                    if (sc_q) begin
                        res_d.reservation = RESV_SC_OK;
                        resvValid_d       = 1'b0;
                    end else if (lr_q) begin
                        res_d.data        = laneRdata;
                        res_d.reservation = RESV_SET;
                        resvValid_d       = 1'b1;
                        resvWord_d        = addr_q[31:2];
                    end else if (write_q) begin
                        if (accResvHit) begin
                            resvValid_d = 1'b0;
                        end
                    end else begin
                        res_d.data = laneRdata;
                    end
                end
`ifdef MEM_RESPONDER_TIMEOUT_EN
                else if (timer_q == TIMER_LIMIT) begin
                    state_d               = STATE_RESP;
                    res_d                 = '0;
                    res_d.exception.valid = 1'b1;
                    res_d.exception.data  = write_q ? STORE_ACCESS_FAULT : LOAD_ACCESS_FAULT;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
`endif
            end
            STATE_RESP: begin
                state_d = STATE_IDLE;
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    // State and request registers; reset abandons any access in flight and drops the reservation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= STATE_IDLE;
            write_q     <= 1'b0;
            lr_q        <= 1'b0;
            sc_q        <= 1'b0;
            size_q      <= SIZE_BYTE;
            addr_q      <= 32'd0;
            data_q      <= 32'd0;
            res_q       <= '0;
            resvValid_q <= 1'b0;
            resvWord_q  <= 30'd0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            lr_q        <= lr_d;
            sc_q        <= sc_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            res_q       <= res_d;
            resvValid_q <= resvValid_d;
            resvWord_q  <= resvWord_d;
        end
    end

`ifdef MEM_RESPONDER_TIMEOUT_EN
    // Cycles spent in ACCESS without an acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= 16'd0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    // Outputs decode straight from state so everything is quiet outside its own phase.
    always_comb begin
        req_ready           = (state_q == STATE_IDLE);
        res_valid           = (state_q == STATE_RESP);
        res_data            = res_valid ? res_q.data : 32'd0;
        res_reservation     = res_valid ? res_q.reservation : RESV_NONE;
        res_exception_valid = res_valid & res_q.exception.valid;
        res_exception_data  = res_valid ? res_q.exception.data : 4'd0;
        sram_en             = (state_q == STATE_ACCESS);
        sram_we             = sram_en & write_q;
        sram_addr           = sram_en ? (addr_q[31:2] - BASE_WORD) : 30'd0;
        sram_wdata          = sram_we ? laneWdata : 32'd0;
        sram_wstrb          = sram_we ? laneWstrb : 4'd0;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a byte-addressed reference memory plus reservation
// model predicts every response, a SRAM model with programmable ack delay
// answers the DUT, and one compare process checks each response pulse.
module tb_mem_responder;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          BYTES = 65536;
    localparam int          TMO   = 8;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_lr;
    logic        req_sc;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        res_valid;
    logic [31:0] res_data;
    logic [1:0]  res_reservation;
    logic        res_exception_valid;
    logic [3:0]  res_exception_data;
    logic        sram_en;
    logic        sram_we;
    logic [29:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_rdata = 32'd0;
    logic        sram_ack = 1'b0;

    mem_responder #(
        .MEM_BASE       (BASE),
        .MEM_BYTES      (BYTES),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_write           (req_write),
        .req_lr              (req_lr),
        .req_sc              (req_sc),
        .req_size            (req_size),
        .req_addr            (req_addr),
        .req_data            (req_data),
        .res_valid           (res_valid),
        .res_data            (res_data),
        .res_reservation     (res_reservation),
        .res_exception_valid (res_exception_valid),
        .res_exception_data  (res_exception_data),
        .sram_en             (sram_en),
        .sram_we             (sram_we),
        .sram_addr           (sram_addr),
        .sram_wdata          (sram_wdata),
        .sram_wstrb          (sram_wstrb),
        .sram_rdata          (sram_rdata),
        .sram_ack            (sram_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycleNo = 0;

    always @(posedge clk) cycleNo <= cycleNo + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected response record.
    typedef struct {
        string       name;
        logic [31:0] data;
        logic [1:0]  resv;
        logic        exV;
        logic [3:0]  exC;
        int          cyc;
    } exp_t;

    exp_t        expQ[$];
    exp_t        cmpE;
    exp_t        tmoE;
    bit          compareOn = 1'b0;
    int          acceptCycle = 0;
    int          lastLatency = 0;
    logic [31:0] lastData = 32'd0;
    logic [1:0]  lastResv = 2'd0;
    logic        lastExV = 1'b0;
    logic [3:0]  lastExC = 4'd0;

    // Reference state: byte memory and reservation.
    logic [7:0]  refMem [0:65535];
    bit          mResvValid = 1'b0;
    logic [29:0] mResvWord = 30'd0;
    int          expAccess = 0;

    // SRAM model.
    logic [31:0] sramMem [0:16383];
    int          ackDelay = 0;
    bit          noAck = 1'b0;
    int          enCycles = 0;
    int          accessCount = 0;
    logic [3:0]  lastWstrb = 4'd0;
    logic [31:0] lastWdata = 32'd0;

    // SRAM answers after ackDelay cycles of sram_en; writes land at the ack.
    always @(negedge clk) begin
        if (sram_en === 1'b1) begin
            if (!noAck && enCycles == ackDelay) begin
                sram_ack   = 1'b1;
                sram_rdata = sramMem[sram_addr[13:0]];
                if (sram_we === 1'b1) begin
                    lastWstrb = sram_wstrb;
                    lastWdata = sram_wdata;
                    for (int b = 0; b < 4; b++)
                        if (sram_wstrb[b]) sramMem[sram_addr[13:0]][8*b +: 8] = sram_wdata[8*b +: 8];
                end
            end else begin
                sram_ack   = 1'b0;
                sram_rdata = 32'd0;
            end
            enCycles++;
        end else begin
            sram_ack   = 1'b0;
            sram_rdata = 32'd0;
            enCycles   = 0;
        end
    end

    always @(posedge clk)
        if (sram_en === 1'b1 && sram_ack === 1'b1 && reset === 1'b0) accessCount <= accessCount + 1;

    // Every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (compareOn) begin
            if (res_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_res_valid", 32'd1, 32'd0);
                end else begin
                    cmpE = expQ.pop_front();
                    checkOutput({cmpE.name, "_cycle"}, cycleNo, cmpE.cyc);
                    checkOutput({cmpE.name, "_data"}, res_data, cmpE.data);
                    checkOutput({cmpE.name, "_resv"}, {30'd0, res_reservation}, {30'd0, cmpE.resv});
                    checkOutput({cmpE.name, "_exv"}, {31'd0, res_exception_valid}, {31'd0, cmpE.exV});
                    checkOutput({cmpE.name, "_exc"}, {28'd0, res_exception_data}, {28'd0, cmpE.exC});
                    checkOutput({cmpE.name, "_ready_low"}, {31'd0, req_ready}, 32'd0);
                    lastLatency = cycleNo - acceptCycle;
                    lastData    = res_data;
                    lastResv    = res_reservation;
                    lastExV     = res_exception_valid;
                    lastExC     = res_exception_data;
                end
            end else if (expQ.size() != 0 && cycleNo > expQ[0].cyc) begin
                checkOutput({expQ[0].name, "_late"}, cycleNo, expQ[0].cyc);
                void'(expQ.pop_front());
            end
        end
    end

    // Reference behaviour of one request, updating memory and reservation.
    task automatic modelRequest(input bit w, input bit lr, input bit sc, input int size,
                                input logic [31:0] addr, input logic [31:0] data,
                                output exp_t e, output bit acc);
        bit          isSc = sc;
        bit          isLr = lr && !sc;
        bit          isWr = isSc || (w && !isLr);
        logic [31:0] rel = addr - BASE;
        int          nBytes = (size == 0) ? 1 : (size == 1) ? 2 : 4;
        bit          mis = (size == 3) || ((addr % nBytes) != 0);
        bit          oor = 64'(rel) >= 64'(BYTES);
        bit          hit = mResvValid && (mResvWord == addr[31:2]);
        acc    = 1'b0;
        e.data = 32'd0;
        e.resv = 2'd0;
        e.exV  = 1'b0;
        e.exC  = 4'd0;
        if (mis) begin
            e.exV = 1'b1;
            e.exC = isWr ? 4'd6 : 4'd4;
        end else if (oor) begin
            e.exV = 1'b1;
            e.exC = isWr ? 4'd7 : 4'd5;
        end else if (isSc && !hit) begin
            e.data     = 32'd1;
            e.resv     = 2'd3;
            mResvValid = 1'b0;
        end else begin
            acc = 1'b1;
            if (isWr) begin
                for (int i = 0; i < nBytes; i++) refMem[int'(rel) + i] = data[8*i +: 8];
                if (isSc) begin
                    e.resv     = 2'd2;
                    mResvValid = 1'b0;
                end else if (hit) begin
                    mResvValid = 1'b0;
                end
            end else begin
                for (int i = 0; i < nBytes; i++) e.data[8*i +: 8] = refMem[int'(rel) + i];
                if (isLr) begin
                    e.resv     = 2'd1;
                    mResvValid = 1'b1;
                    mResvWord  = addr[31:2];
                end
            end
        end
    endtask

    // Present one request when the DUT is ready; unless hang is set, wait for its response.
    task automatic applyStimulus(input string name, input bit w, input bit lr, input bit sc,
                                 input int size, input logic [31:0] addr, input logic [31:0] data,
                                 input int delay, input bit hang);
        exp_t e;
        bit   acc;
        @(negedge clk);
        for (int i = 0; i < 100 && req_ready !== 1'b1; i++) @(negedge clk);
        if (req_ready !== 1'b1) checkOutput({name, "_ready"}, {31'd0, req_ready}, 32'd1);
        ackDelay    = delay;
        noAck       = hang;
        acceptCycle = cycleNo;
        if (!hang) begin
            modelRequest(w, lr, sc, size, addr, data, e, acc);
            e.name = name;
            e.cyc  = cycleNo + (acc ? delay + 2 : 1);
            if (acc) expAccess++;
            expQ.push_back(e);
        end
        req_write = w;
        req_lr    = lr;
        req_sc    = sc;
        req_size  = 2'(size);
        req_addr  = addr;
        req_data  = data;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_lr    = 1'b0;
        req_sc    = 1'b0;
        req_write = 1'b0;
        if (!hang) begin
            for (int i = 0; i < 64 && expQ.size() != 0; i++) @(negedge clk);
            if (expQ.size() != 0) begin
                checkOutput({name, "_timeout"}, expQ.size(), 32'd0);
                expQ.delete();
            end
            checkOutput({name, "_access_count"}, accessCount, expAccess);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    int badCycles;

    initial begin
        for (int i = 0; i < 16384; i++) sramMem[i] = 32'd0;
        for (int i = 0; i < 65536; i++) refMem[i] = 8'd0;
        sramMem[14'h40] = 32'hDEADBEEF;
        refMem[32'h100] = 8'hEF;
        refMem[32'h101] = 8'hBE;
        refMem[32'h102] = 8'hAD;
        refMem[32'h103] = 8'hDE;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_lr    = 1'b0;
        req_sc    = 1'b0;
        req_size  = 2'd0;
        req_addr  = 32'd0;
        req_data  = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("reset_res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("reset_sram_en", {31'd0, sram_en}, 32'd0);
        checkOutput("reset_res_data", res_data, 32'd0);
        checkOutput("reset_res_exv", {31'd0, res_exception_valid}, 32'd0);
        checkOutput("reset_sram_wstrb", {28'd0, sram_wstrb}, 32'd0);
        reset     = 1'b0;
        compareOn = 1'b1;

        $display("[TB] loads, stores and byte lanes");
        applyStimulus("ld_word", 0, 0, 0, 2, 32'h100, 32'd0, 2, 0);
        checkOutput("ld_word_lit_data", lastData, 32'hDEADBEEF);
        checkOutput("ld_word_lit_latency", lastLatency, 32'd4);
        checkOutput("ld_word_lit_exv", {31'd0, lastExV}, 32'd0);
        applyStimulus("st_byte", 1, 0, 0, 0, 32'h103, 32'h000000AA, 0, 0);
        checkOutput("st_byte_lit_wstrb", {28'd0, lastWstrb}, 32'h8);
        checkOutput("st_byte_lit_wdata", lastWdata, 32'hAAAAAAAA);
        applyStimulus("ld_byte", 0, 0, 0, 0, 32'h103, 32'd0, 1, 0);
        checkOutput("ld_byte_lit_data", lastData, 32'h000000AA);
        applyStimulus("st_half", 1, 0, 0, 1, 32'h102, 32'h00001234, 1, 0);
        applyStimulus("ld_word2", 0, 0, 0, 2, 32'h100, 32'd0, 0, 0);
        checkOutput("ld_word2_lit_data", lastData, 32'h1234BEEF);
        applyStimulus("ld_half_hi", 0, 0, 0, 1, 32'h102, 32'd0, 3, 0);

        $display("[TB] faults");
        applyStimulus("ld_half_mis", 0, 0, 0, 1, 32'h101, 32'd0, 0, 0);
        checkOutput("ld_half_mis_lit_exc", {28'd0, lastExC}, 32'd4);
        checkOutput("ld_half_mis_lit_latency", lastLatency, 32'd1);
        applyStimulus("st_word_oor", 1, 0, 0, 2, BASE + BYTES, 32'h1, 0, 0);
        checkOutput("st_word_oor_lit_exc", {28'd0, lastExC}, 32'd7);
        applyStimulus("ld_word_oor", 0, 0, 0, 2, 32'h0001_0004, 32'd0, 0, 0);
        applyStimulus("st_size3", 1, 0, 0, 3, 32'h0, 32'd0, 0, 0);
        applyStimulus("ld_mis_oor", 0, 0, 0, 1, 32'h0001_0001, 32'd0, 0, 0);
        applyStimulus("ld_top_byte", 0, 0, 0, 0, 32'h0000_FFFF, 32'd0, 0, 0);

        $display("[TB] reservations");
        applyStimulus("lr_a", 0, 1, 0, 2, 32'h200, 32'd0, 1, 0);
        checkOutput("lr_a_lit_resv", {30'd0, lastResv}, 32'd1);
        applyStimulus("sc_a", 1, 0, 1, 2, 32'h200, 32'h5555AAAA, 0, 0);
        checkOutput("sc_a_lit_data", lastData, 32'd0);
        checkOutput("sc_a_lit_resv", {30'd0, lastResv}, 32'd2);
        applyStimulus("ld_after_sc", 0, 0, 0, 2, 32'h200, 32'd0, 0, 0);
        applyStimulus("sc_again", 1, 0, 1, 2, 32'h200, 32'h0BAD0BAD, 0, 0);
        checkOutput("sc_again_lit_data", lastData, 32'd1);
        checkOutput("sc_again_lit_resv", {30'd0, lastResv}, 32'd3);
        applyStimulus("lr_b", 0, 1, 0, 2, 32'h200, 32'd0, 0, 0);
        applyStimulus("st_kill", 1, 0, 0, 2, 32'h200, 32'h11, 0, 0);
        applyStimulus("sc_b", 1, 0, 1, 2, 32'h200, 32'h22, 0, 0);
        checkOutput("sc_b_lit_resv", {30'd0, lastResv}, 32'd3);
        applyStimulus("lr_wr", 1, 1, 0, 2, 32'h200, 32'hFFFF, 0, 0);
        applyStimulus("st_other", 1, 0, 0, 2, 32'h204, 32'h33, 1, 0);
        applyStimulus("sc_lrsc", 1, 1, 1, 2, 32'h200, 32'h44, 2, 0);
        checkOutput("sc_lrsc_lit_resv", {30'd0, lastResv}, 32'd2);
        applyStimulus("lr_c", 0, 1, 0, 2, 32'h400, 32'd0, 0, 0);
        applyStimulus("sc_oor", 1, 0, 1, 2, 32'h0001_0400, 32'h55, 0, 0);
        applyStimulus("sc_c", 1, 0, 1, 2, 32'h400, 32'h66, 0, 0);
        checkOutput("sc_c_lit_resv", {30'd0, lastResv}, 32'd2);

        $display("[TB] reset during access");
        applyStimulus("lr_d", 0, 1, 0, 2, 32'h300, 32'd0, 0, 0);
        applyStimulus("ld_hang", 0, 0, 0, 2, 32'h300, 32'd0, 0, 1);
        repeat (2) @(negedge clk);
        checkOutput("hang_sram_en", {31'd0, sram_en}, 32'd1);
        checkOutput("hang_req_ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_mid_sram_en", {31'd0, sram_en}, 32'd0);
        reset      = 1'b0;
        mResvValid = 1'b0;
        applyStimulus("sc_after_rst", 1, 0, 1, 2, 32'h300, 32'h77, 0, 0);
        checkOutput("sc_after_rst_lit_resv", {30'd0, lastResv}, 32'd3);

`ifdef MEM_RESPONDER_TIMEOUT_EN
        $display("[TB] access timeout");
        applyStimulus("ld_timeout", 0, 0, 0, 2, 32'h100, 32'd0, 0, 1);
        tmoE.name = "ld_timeout";
        tmoE.data = 32'd0;
        tmoE.resv = 2'd0;
        tmoE.exV  = 1'b1;
        tmoE.exC  = 4'd5;
        tmoE.cyc  = acceptCycle + 1 + TMO;
        expQ.push_back(tmoE);
        for (int i = 0; i < 64 && expQ.size() != 0; i++) @(negedge clk);
        if (expQ.size() != 0) begin
            checkOutput("ld_timeout_timeout", expQ.size(), 32'd0);
            expQ.delete();
        end
        checkOutput("ld_timeout_lit_exc", {28'd0, lastExC}, 32'd5);
        checkOutput("ld_timeout_lit_latency", lastLatency, 32'd9);
        noAck = 1'b0;
        applyStimulus("ld_after_tmo", 0, 0, 0, 2, 32'h100, 32'd0, 0, 0);
`else
        $display("[TB] unacknowledged access stalls");
        applyStimulus("ld_stall", 0, 0, 0, 2, 32'h100, 32'd0, 0, 1);
        badCycles = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready !== 1'b0 || sram_en !== 1'b1 || res_valid !== 1'b0) badCycles++;
        end
        checkOutput("stall_bad_cycles", badCycles, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("stall_rst_req_ready", {31'd0, req_ready}, 32'd1);
        noAck = 1'b0;
        applyStimulus("ld_after_stall", 0, 0, 0, 2, 32'h100, 32'd0, 0, 0);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder end of the processor core's data-memory request interface (memRead/memWrite).
- Accepts one load, store, LR or SC request at a time and checks its alignment and address range.
- Issues the request to a variable-latency word SRAM port and returns data, a reservation status and an exception record.
- Sits between the processor core and the RAM, in place of a direct memory32 hookup.

Parameters:
- MEM_BASE, 32'h0000_0000, byte address of the first valid location.
- MEM_BYTES, 65536, size of the valid window in bytes; must be a power of two, at least 4.
- TIMEOUT_CYCLES, 255, cycles to wait for sram_ack before faulting (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store/SC, 0 = load/LR
- req_lr  in  1  load-reserved
- req_sc  in  1  store-conditional
- req_size  in  2  0 byte, 1 half, 2 word (3 illegal, treated as misaligned)
- req_addr  in  32  byte address
- req_data  in  32  store data, right-aligned
- res_valid  out  1  one-cycle response pulse
- res_data  out  32  load data, zero-extended and right-aligned; SC result (0 = success, 1 = fail)
- res_reservation  out  2  00 none, 01 reservation set, 10 SC success, 11 SC fail
- res_exception_valid  out  1  exception flag
- res_exception_data  out  4  RISC-V cause code
- sram_en  out  1  SRAM access strobe
- sram_we  out  1  SRAM write
- sram_addr  out  30  word address, relative to MEM_BASE
- sram_wdata  out  32  lane-shifted write data
- sram_wstrb  out  4  byte strobes
- sram_rdata  in  32  read data, valid with sram_ack
- sram_ack  in  1  access complete

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: all outputs 0 except req_ready = 1. State goes to IDLE and the reservation is cleared.
- IDLE: req_ready = 1. On req_valid, latch the request and perform the checks.
  - Misaligned: addr[0] set with half size, addr[1:0] nonzero with word size, or size = 3. Goes to RESP with cause 4 (load) or 6 (store).
  - Out of range: addr - MEM_BASE >= MEM_BYTES, computed as a 32-bit unsigned subtraction. Goes to RESP with cause 5 (load) or 7 (store).
  - Misaligned takes priority over out of range.
  - SC with no valid reservation, or a reservation address (word granularity) that does not match: goes to RESP without an SRAM access. res_data = 1, reservation = 11.
  - Otherwise goes to ACCESS.
- ACCESS:
  - sram_en is held high until sram_ack.
  - Write strobes: byte 4'b0001 << addr[1:0], half 4'b0011 << addr[1:0], word 4'hF.
  - sram_wdata is req_data replicated across lanes.
  - On sram_ack, capture the read data shifted right by 8*addr[1:0] and masked to the size. Then go to RESP.
  - req_ready = 0 throughout.
- RESP: res_valid = 1 for exactly one cycle, then return to IDLE. req_ready = 0 in this cycle, so the minimum latency is 2 cycles for a faulting request and 3 cycles for an SRAM request with same-cycle ack.
- Reservation tracking:
  - A successful LR sets the reservation valid with its word address and reports 01.
  - Any SC (success or fail) clears the reservation.
  - A successful plain store to the reserved word clears it.
  - Faulting requests leave the reservation unchanged.
- Simultaneous events:
  - req_lr and req_sc both high is treated as SC.
  - req_lr together with req_write is treated as LR (req_write is ignored).
- reset mid-ACCESS: the state is abandoned immediately and sram_en drops in the next cycle. The SRAM must tolerate an abandoned access.
- sram_ack outside ACCESS is ignored.

Optional Feature:
- Macro: MEM_RESPONDER_TIMEOUT_EN.
- Defined: an 8..16-bit counter runs in ACCESS. When it reaches TIMEOUT_CYCLES without sram_ack, the responder drops sram_en and goes to RESP with an access fault (5 or 7). The reservation is unchanged.
- Undefined: no counter; ACCESS waits forever.

Decomposition:
- Package mem_responder_pkg holds:
  - cause constants (LOAD_MISALIGNED = 4, LOAD_ACCESS_FAULT = 5, STORE_MISALIGNED = 6, STORE_ACCESS_FAULT = 7);
  - the reservation-code enum;
  - the size enum;
  - the packed response struct {data, reservation, exception{valid, data}}, matching the memRead_res layout.
- One sub-module, mem_lane_align: combinational strobe/shift/mask generation for both write and read directions.

Test Plan:
- Word load at 0x100 where SRAM word 0x40 = 32'hDEADBEEF, ack after 2 cycles -> res_valid 4 cycles after acceptance, res_data 32'hDEADBEEF, exception 0.
- Byte store of 32'h000000AA at 0x103 -> sram_wstrb 4'b1000, sram_wdata 32'hAAAAAAAA; a following byte load at 0x103 returns 32'h000000AA.
- Half load at 0x101 -> no sram_en; res_exception_valid = 1, data = 4. Word store at MEM_BASE + MEM_BYTES -> exception 7.
- LR at 0x200 (reservation 01), then SC at 0x200 -> res_data 0, reservation 10, SRAM written. A second SC at 0x200 -> res_data 1, reservation 11, no sram_en.
- LR at 0x200, store at 0x200, SC at 0x200 -> SC fails (11). Assert reset during ACCESS -> req_ready = 1 and sram_en = 0 one cycle later; a following SC fails.
- With MEM_RESPONDER_TIMEOUT_EN, TIMEOUT_CYCLES = 8, no ack on a load -> exception 5 at cycle 8 of ACCESS. Without the macro, the block stays in ACCESS and req_ready stays 0.
